// File: rtl/addr_burst_gen.sv
// Burst address generator: takes a base address and beat count, emits
// one address per accepted beat, stepping by STRIDE, flagging the last.
//
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - burst request present
//   in_ready  - block can accept a request (IDLE and not in reset)
//   in_addr   - base address of the burst
//   in_len    - number of beats minus 1
//   out_valid - out_addr holds a valid beat
//   out_ready - downstream accepts the beat
//   out_addr  - current burst address
//   out_last  - current beat is the final beat
//   busy      - a burst is in progress
module addr_burst_gen #(
    parameter logic [15:0] STRIDE = 16'h0001,
    parameter int          LEN_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_addr,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_addr,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      addr_nx;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out_addr <= 16'h0000;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            out_addr <= addr_nx;
            cnt      <= cnt_nx;
        end
    end

    // out_addr doubles as the address register, so it naturally keeps
    // the last beat's value once the burst returns to IDLE.
    always_comb begin
        state_nx  = state;
        addr_nx   = out_addr;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    addr_nx  = in_addr;
                    cnt_nx   = in_len;
                    state_nx = BURST;
                end
            end
            BURST: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (cnt == '0);
                if (out_ready) begin
                    if (out_last) begin
                        state_nx = IDLE;
                    end else begin
                        addr_nx = out_addr + STRIDE;
                        cnt_nx  = cnt - 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_addr_burst_gen.sv
// Randomized and directed bench for addr_burst_gen with a beat
// scoreboard filled by the driver and drained by a monitor.
`timescale 1ns/1ps
module tb_addr_burst_gen;

    localparam logic [15:0] STRIDE = 16'h0001;
    localparam int          LEN_W  = 4;

    typedef struct {
        logic [15:0] addr;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_addr;
    logic [LEN_W-1:0] in_len;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_addr;
    logic             out_last;
    logic             busy;

    int    tests = 0;
    int    fails = 0;
    bit    ready_rand = 1'b0;
    beat_t q[$];

    addr_burst_gen #(
        .STRIDE(STRIDE),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_len   (in_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: beat i of a burst is base + i*STRIDE mod 2^16,
    // last only on beat in_len.
    task automatic push(input logic [15:0] a, input int l);
        beat_t b;
        for (int i = 0; i <= l; i++) begin
            b.addr = 16'((32'(a) + i * 32'(STRIDE)) % 65536);
            b.last = (i == l);
            q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input int l);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        chk("req_accept_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_addr  = a;
        in_len   = LEN_W'(l);
        push(a, l);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (busy && cyc < 300);
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the
    // next rising edge, so compare the presented beat now.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %h expected none",
                             out_addr);
                end else begin
                    b = q.pop_front();
                    chk("beat_addr", 32'(out_addr), 32'(b.addr));
                    chk("beat_last", 32'(out_last), 32'(b.last));
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (ready_rand) out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        logic [15:0] a;
        int l;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_len    = '0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Basic 4-beat burst, no backpressure.
        out_ready = 1'b1;
        send(16'h0001, 3);
        wait_idle(cyc);
        chk("b4_cycles", 32'(cyc), 32'd4);
        chk("b4_hold_addr", 32'(out_addr), 32'h0004);
        chk("b4_in_ready", 32'(in_ready), 32'd1);

        // Address wrap.
        send(16'hFFFF, 1);
        wait_idle(cyc);
        chk("wrap_cycles", 32'(cyc), 32'd2);
        chk("wrap_hold_addr", 32'(out_addr), 32'h0000);

        // Backpressure on the second beat.
        send(16'h0008, 2);
        step();
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_addr", 32'(out_addr), 32'h0009);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        wait_idle(cyc);
        chk("bp_done_addr", 32'(out_addr), 32'h000A);

        // Single-beat burst.
        send(16'h0004, 0);
        chk("single_last", 32'(out_last), 32'd1);
        wait_idle(cyc);
        chk("single_cycles", 32'(cyc), 32'd1);
        chk("single_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-burst after the second beat.
        send(16'h0100, 7);
        step();
        step();
        rst = 1'b1;
        q.delete();
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(out_addr), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_release", 32'(in_ready), 32'd1);
        repeat (3) step();
        chk("no_resume", 32'(out_valid), 32'd0);

        // Request held during a burst is only taken once idle.
        send(16'h0010, 3);
        in_valid = 1'b1;
        in_addr  = 16'h0002;
        in_len   = LEN_W'(1);
        push(16'h0002, 1);
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("ignore_cycles", 32'(n), 32'd4);
        step();
        in_valid = 1'b0;
        wait_idle(cyc);
        chk("ignore_done_addr", 32'(out_addr), 32'h0003);

        // Randomized bursts with random backpressure.
        ready_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0)
                a = 16'hFFF0 + 16'($urandom_range(0, 15));
            else
                a = 16'($urandom);
            l = $urandom_range(0, 15);
            send(a, l);
            wait_idle(cyc);
            chk("rand_hold_addr", 32'(out_addr),
                32'((32'(a) + l * 32'(STRIDE)) % 65536));
        end
        ready_rand = 1'b0;
        out_ready  = 1'b1;
        repeat (3) step();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/addr_burst_gen.md
ADDR_BURST_GEN -- requirements
Module: addr_burst_gen

Interface
REQ-001 SHALL have parameter STRIDE, default 16'h0001, added to the address after each accepted output beat.
REQ-002 SHALL have parameter LEN_W, default 4, the width of the burst-length field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, a burst request is present.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a request.
REQ-007 SHALL have port in_addr, input, 16, the base address produced by the upstream address-select stage.
REQ-008 SHALL have port in_len, input, LEN_W, the number of beats minus 1.
REQ-009 SHALL have port out_valid, output, 1, out_addr holds a valid beat.
REQ-010 SHALL have port out_ready, input, 1, the downstream accepts the beat.
REQ-011 SHALL have port out_addr, output, 16, the current burst address.
REQ-012 SHALL have port out_last, output, 1, the current beat is the final beat of the burst.
REQ-013 SHALL have port busy, output, 1, a burst is in progress.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and BURST.
REQ-015 SHALL drive in_ready = 1 only in IDLE with rst low; in_ready SHALL be 0 in BURST.
REQ-016 SHALL accept a request when in_valid && in_ready at a clock edge: capture in_addr into out_addr and in_len into the remaining-beat counter, then move to BURST.
REQ-017 SHALL assert out_valid in the cycle after acceptance (1-cycle latency) and SHALL hold it high for the whole of BURST.
REQ-018 SHALL drive busy = 1 exactly while in BURST.
REQ-019 SHALL hold out_addr, out_last and the counter stable while out_valid && !out_ready (backpressure); it SHALL NOT drop or skip beats.
REQ-020 SHALL, on out_valid && out_ready with counter != 0, set out_addr to out_addr + STRIDE modulo 2^16 and decrement the counter by 1.
REQ-021 SHALL drive out_last = 1 exactly when in BURST and the counter == 0.
REQ-022 SHALL, on out_valid && out_ready && out_last, return to IDLE and deassert out_valid and out_last; in_ready SHALL rise the next cycle, with no same-cycle re-accept.
REQ-023 SHALL produce exactly in_len+1 beats per burst; in_len = 0 SHALL give a single beat with out_last = 1.
REQ-024 SHALL wrap the address from 16'hFFFF + STRIDE to the low 16 bits, with no flag and no stall.
REQ-025 SHALL ignore in_valid while in BURST and SHALL NOT alter the captured state.
REQ-026 SHALL hold out_addr at its last burst value while in IDLE.

Reset
REQ-027 SHALL, on any clock edge with rst = 1, force state IDLE, out_valid 0, out_last 0, busy 0, out_addr 16'h0000 and counter 0.
REQ-028 SHALL let rst take priority over any simultaneous handshake, including mid-burst; the aborted burst SHALL NOT resume.
REQ-029 SHALL hold in_ready at 0 while rst = 1 and raise it to 1 in the first cycle after rst falls.

Verification
REQ-030 SHALL pass: in_addr 16'h0001, in_len 3, out_ready held 1 -> out_addr 0001, 0002, 0003, 0004 on consecutive cycles, out_last only on 0004, then IDLE.
REQ-031 SHALL pass: in_addr 16'hFFFF, in_len 1 -> beats FFFF then 0000, with out_last on 0000.
REQ-032 SHALL pass: in_addr 16'h0008, in_len 2, out_ready low for 3 cycles on the second beat -> 0009 held with out_valid high, then 000A with last; total of 3 beats.
REQ-033 SHALL pass: in_len 0, in_addr 16'h0004 -> one beat 0004 with out_last 1; in_ready returns 1 the next cycle.
REQ-034 SHALL pass: rst pulsed after the 2nd beat of a len-7 burst -> the next cycle shows out_valid 0, busy 0, out_addr 0000, and in_ready 1 after rst falls.
REQ-035 SHALL pass: a new in_valid (in_addr 16'h0002) during BURST is ignored; it is accepted only after the burst completes and in_ready is 1.
